tx_arp_gen: RTL and testbench

- Downstream stage of the receive-side ARP analyser. Consumes its ack_en/get_en/get_mac_pc pulses.
- Builds the 28-byte ARP payload for two cases:
  - a reply to a valid PC request;
  - a locally triggered request to resolve cfg_ip_pc.
- Emits the payload as a 32-bit sop/eop/vld/mod stream with ready back-pressure, toward the Ethernet framing stage.
- Also holds the resolved PC MAC for the UDP/IP transmit path.

---
 rtl/tx_arp_gen.sv | 181 ++++++++++++++++++
 tb/tb_tx_arp_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arp_gen.sv
// Purpose: builds the 28-byte ARP reply/request payload and holds the resolved PC MAC.
// Latency: ack_en/req_en in cycle N -> first word (sop) presented in cycle N+2.
// Backpressure: dout_vld held for the whole packet; word counter advances only on dout_vld && dout_rdy.
module tx_arp_gen #(
    parameter int MAC_ADDR_W = 48,
    parameter int IP_ADDR_W  = 32,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MAC_ADDR_W-1:0] cfg_mac_local,
    input  logic [IP_ADDR_W-1:0]  cfg_ip_local,
    input  logic [IP_ADDR_W-1:0]  cfg_ip_pc,
    input  logic                  ack_en,
    input  logic                  get_en,
    input  logic [MAC_ADDR_W-1:0] get_mac_pc,
    input  logic                  req_en,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_vld,
    output logic                  dout_sop,
    output logic                  dout_eop,
    output logic [1:0]            dout_mod,
    input  logic                  dout_rdy,
    output logic [MAC_ADDR_W-1:0] mac_pc,
    output logic                  mac_pc_vld,
    output logic                  busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [2:0]  LAST_WORD = 3'd6;
    localparam logic [15:0] OPER_REQ  = 16'h0001;
    localparam logic [15:0] OPER_REP  = 16'h0002;
    // htype=Ethernet(0x0001), ptype=IPv4(0x0800)
    localparam logic [31:0] WORD0     = 32'h0001_0800;
    // hlen=6, plen=4
    localparam logic [15:0] HPLEN     = 16'h0604;

    state_t                  state_q, state_d;
    logic                    pend_rep_q, pend_rep_d;
    logic                    pend_req_q, pend_req_d;
    logic [MAC_ADDR_W-1:0]   rep_mac_q, rep_mac_d;
    logic [2:0]              word_cnt_q, word_cnt_d;
    logic                    oper_rep_q, oper_rep_d;
    logic [MAC_ADDR_W-1:0]   tgt_mac_q, tgt_mac_d;
    logic [MAC_ADDR_W-1:0]   mac_pc_q, mac_pc_d;
    logic                    mac_pc_vld_q, mac_pc_vld_d;
    logic                    busy_q, busy_d;

    logic                    take_rep;
    logic                    take_req;
    logic                    accept;
    logic [15:0]             oper;
    logic [DATA_W-1:0]       word_dat;

    assign accept = (state_q == ST_SEND) && dout_rdy;
    assign oper   = oper_rep_q ? OPER_REP : OPER_REQ;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= 3'd0;
            oper_rep_q <= 1'b0;
            tgt_mac_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            oper_rep_q <= oper_rep_d;
            tgt_mac_q  <= tgt_mac_d;
        end
    end

    // Next state: reply wins over request; oper and target MAC snapshotted on entry to SEND
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        oper_rep_d = oper_rep_q;
        tgt_mac_d  = tgt_mac_q;
        take_rep   = 1'b0;
        take_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_rep_q) begin
                    state_d    = ST_SEND;
                    word_cnt_d = 3'd0;
                    oper_rep_d = 1'b1;
                    tgt_mac_d  = rep_mac_q;
                    take_rep   = 1'b1;
                end else if (pend_req_q) begin
                    state_d    = ST_SEND;
                    word_cnt_d = 3'd0;
                    oper_rep_d = 1'b0;
                    tgt_mac_d  = '0;
                    take_req   = 1'b1;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    if (word_cnt_q == LAST_WORD) begin
                        state_d    = ST_IDLE;
                        word_cnt_d = 3'd0;
                    end else begin
                        word_cnt_d = word_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                word_cnt_d = 3'd0;
            end
        endcase
    end

    // Pending/resolved-MAC/busy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rep_q   <= 1'b0;
            pend_req_q   <= 1'b0;
            rep_mac_q    <= '0;
            mac_pc_q     <= '0;
            mac_pc_vld_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pend_rep_q   <= pend_rep_d;
            pend_req_q   <= pend_req_d;
            rep_mac_q    <= rep_mac_d;
            mac_pc_q     <= mac_pc_d;
            mac_pc_vld_q <= mac_pc_vld_d;
            busy_q       <= busy_d;
        end
    end

    // A new pulse in the same cycle as the flag is consumed keeps the flag set
    always_comb begin
        pend_rep_d   = ack_en | (pend_rep_q & ~take_rep);
        pend_req_d   = req_en | (pend_req_q & ~take_req);
        rep_mac_d    = ack_en ? get_mac_pc : rep_mac_q;
        mac_pc_d     = get_en ? get_mac_pc : mac_pc_q;
        mac_pc_vld_d = mac_pc_vld_q | get_en;
        busy_d       = (state_d == ST_SEND) | pend_rep_d | pend_req_d;
    end

    // Payload word select, big-endian
    always_comb begin
        word_dat = '0;
        case (word_cnt_q)
            3'd0:    word_dat = WORD0;
            3'd1:    word_dat = {HPLEN, oper};
            3'd2:    word_dat = cfg_mac_local[47:16];
            3'd3:    word_dat = {cfg_mac_local[15:0], cfg_ip_local[31:16]};
            3'd4:    word_dat = {cfg_ip_local[15:0], tgt_mac_q[47:32]};
            3'd5:    word_dat = tgt_mac_q[31:0];
            3'd6:    word_dat = cfg_ip_pc;
            default: word_dat = '0;
        endcase
    end

    // Stream outputs are zero outside SEND so reset and idle look identical downstream
    always_comb begin
        dout     = '0;
        dout_vld = 1'b0;
        dout_sop = 1'b0;
        dout_eop = 1'b0;
        dout_mod = 2'b00;
        if (state_q == ST_SEND) begin
            dout     = word_dat;
            dout_vld = 1'b1;
            dout_sop = (word_cnt_q == 3'd0);
            dout_eop = (word_cnt_q == LAST_WORD);
        end
    end

    assign mac_pc     = mac_pc_q;
    assign mac_pc_vld = mac_pc_vld_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tx_arp_gen.sv
// Purpose: directed bench for tx_arp_gen (reply, request, back-pressure, collision, resolve, reset).
// Latency: checks first word two cycles after the trigger pulse.
// Backpressure: drives dout_rdy patterns and checks words hold while not accepted.
module tb_tx_arp_gen;

    logic        clk;
    logic        rst_n;
    logic [47:0] cfg_mac_local;
    logic [31:0] cfg_ip_local;
    logic [31:0] cfg_ip_pc;
    logic        ack_en;
    logic        get_en;
    logic [47:0] get_mac_pc;
    logic        req_en;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic [1:0]  dout_mod;
    logic        dout_rdy;
    logic [47:0] mac_pc;
    logic        mac_pc_vld;
    logic        busy;

    int errors;
    int checks;

    localparam logic [47:0] MAC_A = 48'hA0B0_C0D0_E0F0;
    localparam logic [47:0] MAC_B = 48'h0102_0304_0506;

    localparam logic [31:0] EXP_A [7] = '{32'h00010800, 32'h06040002, 32'h00112233,
        32'h4455C0A8, 32'h0002A0B0, 32'hC0D0E0F0, 32'hC0A80003};
    localparam logic [31:0] EXP_B [7] = '{32'h00010800, 32'h06040002, 32'h00112233,
        32'h4455C0A8, 32'h00020102, 32'h03040506, 32'hC0A80003};
    localparam logic [31:0] EXP_Q [7] = '{32'h00010800, 32'h06040001, 32'h00112233,
        32'h4455C0A8, 32'h00020000, 32'h00000000, 32'hC0A80003};

    // accepted-word monitor
    logic [31:0] mon_q [$];
    int          sop_cnt;
    int          eop_cnt;

    tx_arp_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_mac_local (cfg_mac_local),
        .cfg_ip_local  (cfg_ip_local),
        .cfg_ip_pc     (cfg_ip_pc),
        .ack_en        (ack_en),
        .get_en        (get_en),
        .get_mac_pc    (get_mac_pc),
        .req_en        (req_en),
        .dout          (dout),
        .dout_vld      (dout_vld),
        .dout_sop      (dout_sop),
        .dout_eop      (dout_eop),
        .dout_mod      (dout_mod),
        .dout_rdy      (dout_rdy),
        .mac_pc        (mac_pc),
        .mac_pc_vld    (mac_pc_vld),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        sop_cnt = 0;
        eop_cnt = 0;
    end

    always @(negedge clk) begin
        if (dout_vld && dout_rdy) begin
            mon_q.push_back(dout);
            if (dout_sop) sop_cnt++;
            if (dout_eop) eop_cnt++;
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout, dout_vld, dout_sop, dout_eop, dout_mod, busy, mac_pc, mac_pc_vld} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs not zero (dout=%h vld=%b busy=%b mac_vld=%b)",
                     dout, dout_vld, busy, mac_pc_vld);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({dout_vld, busy, mac_pc_vld} !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle: vld=%b busy=%b mac_vld=%b want 000", dout_vld, busy, mac_pc_vld);
            end
        end
    endtask

    task automatic test_reply;
        @(posedge clk); #1 ack_en = 1'b1; get_mac_pc = MAC_A; dout_rdy = 1'b1;
        @(posedge clk); #1 ack_en = 1'b0; get_mac_pc = '0;
        @(negedge clk);
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL reply_lat_n1: dout_vld=%b want 0", dout_vld);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if ({dout_vld, dout, dout_sop, dout_eop, dout_mod} !== {1'b1, EXP_A[i], (i == 0), (i == 6), 2'b00}) begin
                errors++;
                $display("FAIL reply_w%0d: vld=%b dout=%h sop=%b eop=%b mod=%0d want vld=1 dout=%h sop=%b eop=%b mod=0",
                         i, dout_vld, dout, dout_sop, dout_eop, dout_mod, EXP_A[i], (i == 0), (i == 6));
            end
            if (i == 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL reply_busy: busy=%b want 1", busy);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({dout_vld, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reply_end: vld=%b busy=%b want 0 0", dout_vld, busy);
        end
    endtask

    task automatic test_request;
        @(posedge clk); #1 req_en = 1'b1; dout_rdy = 1'b1;
        @(posedge clk); #1 req_en = 1'b0;
        @(negedge clk);
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL req_lat_n1: dout_vld=%b want 0", dout_vld);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if ({dout_vld, dout, dout_sop, dout_eop} !== {1'b1, EXP_Q[i], (i == 0), (i == 6)}) begin
                errors++;
                $display("FAIL req_w%0d: vld=%b dout=%h sop=%b eop=%b want vld=1 dout=%h sop=%b eop=%b",
                         i, dout_vld, dout, dout_sop, dout_eop, EXP_Q[i], (i == 0), (i == 6));
            end
        end
        @(negedge clk);
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL req_end: vld=%b want 0", dout_vld);
        end
    endtask

    task automatic test_backpressure;
        @(posedge clk); #1 ack_en = 1'b1; get_mac_pc = MAC_A; dout_rdy = 1'b0;
        @(posedge clk); #1 ack_en = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1 dout_rdy = (k % 2 == 1);
            @(negedge clk);
            checks++;
            if ({dout_vld, dout, dout_sop, dout_eop} !== {1'b1, EXP_A[k/2], (k/2 == 0), (k/2 == 6)}) begin
                errors++;
                $display("FAIL bp_cyc%0d: vld=%b dout=%h sop=%b eop=%b want vld=1 dout=%h sop=%b eop=%b",
                         k, dout_vld, dout, dout_sop, dout_eop, EXP_A[k/2], (k/2 == 0), (k/2 == 6));
            end
        end
        @(posedge clk); #1 dout_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: vld=%b want 0 after 14 SEND cycles", dout_vld);
        end
    endtask

    task automatic test_collision;
        int base;
        int sop_base;
        int eop_base;
        int cyc;
        logic [31:0] exp;
        base     = mon_q.size();
        sop_base = sop_cnt;
        eop_base = eop_cnt;
        @(posedge clk); #1 ack_en = 1'b1; req_en = 1'b1; get_mac_pc = MAC_A; dout_rdy = 1'b1;
        @(posedge clk); #1 ack_en = 1'b0; req_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 ack_en = 1'b1; get_mac_pc = MAC_B;
        @(posedge clk); #1 ack_en = 1'b0; get_mac_pc = '0;
        cyc = 0;
        while ((mon_q.size() - base) < 21 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if ((mon_q.size() - base) != 21) begin
            errors++;
            $display("FAIL coll_count: got %0d words want 21", mon_q.size() - base);
        end else begin
            for (int i = 0; i < 21; i++) begin
                exp = (i < 7) ? EXP_A[i] : (i < 14) ? EXP_B[i-7] : EXP_Q[i-14];
                checks++;
                if (mon_q[base+i] !== exp) begin
                    errors++;
                    $display("FAIL coll_w%0d: got %h want %h", i, mon_q[base+i], exp);
                end
            end
        end
        checks++;
        if ((sop_cnt - sop_base) != 3 || (eop_cnt - eop_base) != 3) begin
            errors++;
            $display("FAIL coll_sop_eop: sop=%0d eop=%0d want 3 3", sop_cnt - sop_base, eop_cnt - eop_base);
        end
    endtask

    task automatic test_resolve;
        int base;
        base = mon_q.size();
        @(posedge clk); #1 get_en = 1'b1; get_mac_pc = 48'h6655_4433_2211;
        @(posedge clk); #1 get_en = 1'b0; get_mac_pc = '0;
        @(negedge clk);
        checks++;
        if ({mac_pc, mac_pc_vld} !== {48'h6655_4433_2211, 1'b1}) begin
            errors++;
            $display("FAIL resolve_next: mac_pc=%h vld=%b want 665544332211 1", mac_pc, mac_pc_vld);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({mac_pc, mac_pc_vld, busy} !== {48'h6655_4433_2211, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL resolve_sticky: mac_pc=%h vld=%b busy=%b want 665544332211 1 0", mac_pc, mac_pc_vld, busy);
        end
        checks++;
        if (mon_q.size() != base) begin
            errors++;
            $display("FAIL resolve_nopkt: got %0d words want 0", mon_q.size() - base);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        base = mon_q.size();
        @(posedge clk); #1 ack_en = 1'b1; get_mac_pc = MAC_A; dout_rdy = 1'b1;
        @(posedge clk); #1 ack_en = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, dout_vld, dout_sop, dout_eop, dout_mod, busy, mac_pc, mac_pc_vld} !== '0) begin
            errors++;
            $display("FAIL rstmid_out: dout=%h vld=%b busy=%b mac_pc=%h mac_vld=%b want all 0",
                     dout, dout_vld, busy, mac_pc, mac_pc_vld);
        end
        checks++;
        if (mon_q.size() - base != 4) begin
            errors++;
            $display("FAIL rstmid_words: got %0d accepted words before reset want 4", mon_q.size() - base);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({dout_vld, busy} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_idle%0d: vld=%b busy=%b want 0 0", i, dout_vld, busy);
            end
        end
        checks++;
        if (mon_q.size() - base != 4) begin
            errors++;
            $display("FAIL rstmid_nopkt: got %0d words want 4", mon_q.size() - base);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        cfg_mac_local = 48'h0011_2233_4455;
        cfg_ip_local  = 32'hC0A8_0002;
        cfg_ip_pc     = 32'hC0A8_0003;
        ack_en        = 1'b0;
        get_en        = 1'b0;
        get_mac_pc    = '0;
        req_en        = 1'b0;
        dout_rdy      = 1'b1;

        test_reset;
        test_reply;
        repeat (2) @(posedge clk);
        test_request;
        repeat (2) @(posedge clk);
        test_backpressure;
        repeat (2) @(posedge clk);
        test_collision;
        test_resolve;
        test_reset_mid;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
